// File: rtl/led_event_timer.sv
// led_event_timer: turns raw events into tick-timed LED enables and runs the maintenance press-and-hold FSM.
// Optional: define LED_EVT_STICKY_EN to latch channel 5 (fault) until clear_all or reset.

module led_event_timer #(
    parameter int TICK_DIV        = 10000000,
    parameter int HOLD_TICKS      = 10,
    parameter int MTNE_HOLD_TICKS = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] event_in,
    input  logic       clear_all,
    input  logic       mtne_btn,
    output logic [5:0] led_enable,
    output logic       mtne_mode,
    output logic       tick
);

    localparam int            CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
    localparam logic [7:0]    HOLD_V   = 8'(HOLD_TICKS);
    localparam logic [7:0]    MTNE_V   = 8'(MTNE_HOLD_TICKS);
`ifdef LED_EVT_STICKY_EN
    localparam bit STICKY5 = 1'b1;
`else
    localparam bit STICKY5 = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ON_HELD,
        S_ON,
        S_EXIT
    } mtne_state_t;

    logic [CW-1:0] pre_cnt;
    logic [5:0]    ev_s1;
    logic [5:0]    ev_s2;
    logic [5:0]    ev_s3;
    logic [5:0]    ev_edge;
    logic [1:0]    warm;
    logic          btn_s1;
    logic          btn;
    logic [7:0]    timer [6];
    logic [7:0]    hold_cnt;
    mtne_state_t   state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (pre_cnt == DIV_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == DIV_LAST);

    // warm gates edges until the history flop holds a real post-reset sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ev_s1  <= '0;
            ev_s2  <= '0;
            ev_s3  <= '0;
            btn_s1 <= 1'b0;
            btn    <= 1'b0;
            warm   <= '0;
        end else begin
            ev_s1  <= event_in;
            ev_s2  <= ev_s1;
            ev_s3  <= ev_s2;
            btn_s1 <= mtne_btn;
            btn    <= btn_s1;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign ev_edge = (warm == 2'd3) ? (ev_s2 & ~ev_s3) : 6'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_enable <= '0;
            for (int i = 0; i < 6; i++) begin
                timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (clear_all) begin
                    timer[i]      <= '0;
                    led_enable[i] <= 1'b0;
                end else if (ev_edge[i]) begin
                    timer[i]      <= HOLD_V;
                    led_enable[i] <= 1'b1;
                end else if (tick && timer[i] != 8'd0 && !(STICKY5 && i == 5)) begin
                    timer[i] <= timer[i] - 8'd1;
                    if (timer[i] == 8'd1) begin
                        led_enable[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            mtne_mode <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (btn) begin
                        state    <= S_ARM;
                        hold_cnt <= '0;
                    end
                end
                S_ARM: begin
                    if (!btn) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        hold_cnt <= hold_cnt + 8'd1;
                        if (hold_cnt + 8'd1 == MTNE_V) begin
                            state     <= S_ON_HELD;
                            mtne_mode <= 1'b1;
                        end
                    end
                end
                S_ON_HELD: begin
                    if (!btn) begin
                        state <= S_ON;
                    end
                end
                S_ON: begin
                    if (btn) begin
                        state     <= S_EXIT;
                        mtne_mode <= 1'b0;
                    end
                end
                S_EXIT: begin
                    if (!btn) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    mtne_mode <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_event_timer.sv
// tb_led_event_timer: directed vector table, hand sequences and random run against a deadline-based model.
// Honours LED_EVT_STICKY_EN for the channel 5 expectations.

module tb_led_event_timer;

    localparam int TD = 4;
    localparam int HT = 3;
    localparam int MT = 2;
`ifdef LED_EVT_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] event_in = '0;
    logic       clear_all = 1'b0;
    logic       mtne_btn = 1'b0;
    logic [5:0] led_enable;
    logic       mtne_mode;
    logic       tick;

    led_event_timer #(
        .TICK_DIV       (TD),
        .HOLD_TICKS     (HT),
        .MTNE_HOLD_TICKS(MT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .event_in  (event_in),
        .clear_all (clear_all),
        .mtne_btn  (mtne_btn),
        .led_enable(led_enable),
        .mtne_mode (mtne_mode),
        .tick      (tick)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    int cur_p  = 0;

    // model: input history, per-channel switch-off clock, maintenance level
    logic [5:0] h_ev [3];
    logic       hb [3];
    int         off_t [6];
    bit         m_mode, m_armed, m_need;
    int         m_held;

    typedef struct {
        int         p;
        logic [5:0] ev;
        logic       clr;
        logic [5:0] en;
        logic       tk;
    } vec_t;

    vec_t tv[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            h_ev[i] = '0;
            hb[i]   = 1'b0;
        end
        for (int i = 0; i < 6; i++) off_t[i] = 0;
        m_mode  = 0;
        m_armed = 0;
        m_need  = 0;
        m_held  = 0;
    endtask

    task automatic model_step();
        logic [5:0] edge_v;
        logic       b;
        bit         tu;
        edge_v = (cur_p >= 4) ? (h_ev[1] & ~h_ev[2]) : 6'd0;
        b      = hb[1];
        tu     = (cur_p % TD == 0);
        for (int i = 0; i < 6; i++) begin
            if (clear_all) off_t[i] = 0;
            else if (edge_v[i])
                off_t[i] = (STICKY && i == 5) ? 32'h7fffffff
                         : TD * (cur_p / TD + 1) + TD * (HT - 1);
        end
        if (!b) begin
            m_armed = 0;
            m_held  = 0;
            m_need  = 0;
        end else if (m_need) begin
        end else if (m_mode) begin
            m_mode = 0;
            m_need = 1;
        end else if (!m_armed) begin
            m_armed = 1;
            m_held  = 0;
        end else if (tu) begin
            m_held++;
            if (m_held == MT) begin
                m_mode  = 1;
                m_need  = 1;
                m_armed = 0;
            end
        end
        h_ev[2] = h_ev[1];
        h_ev[1] = h_ev[0];
        h_ev[0] = event_in;
        hb[2]   = hb[1];
        hb[1]   = hb[0];
        hb[0]   = mtne_btn;
    endtask

    function automatic logic [5:0] model_en();
        logic [5:0] e;
        for (int i = 0; i < 6; i++) e[i] = (cur_p < off_t[i]);
        return e;
    endfunction

    task automatic clk();
        @(posedge clock);
        cur_p++;
        model_step();
        @(negedge clock);
    endtask

    task automatic run_to(int p);
        while (cur_p < p) clk();
    endtask

    task automatic do_reset(bit chk_now);
        reset = 1'b1;
        #1;
        if (chk_now) begin
            chk("rst_en", 32'(led_enable), 32'h0);
            chk("rst_mode", 32'(mtne_mode), 32'h0);
            chk("rst_tick", 32'(tick), 32'h0);
        end
        @(negedge clock);
        @(negedge clock);
        event_in  = '0;
        clear_all = 1'b0;
        mtne_btn  = 1'b0;
        reset     = 1'b0;
        cur_p     = 0;
        model_reset();
    endtask

    task automatic add_vec(int p, logic [5:0] ev, logic clr, logic [5:0] en, logic tk);
        tv.push_back('{p, ev, clr, en, tk});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got timeout want $finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] r;

        model_reset();
        @(negedge clock);
        do_reset(1'b1);

        // p = posedge index after reset; ev/clr applied before p, outputs checked after it
        add_vec(4,  6'h01, 1'b0, 6'h00, 1'b0);
        add_vec(5,  6'h00, 1'b0, 6'h00, 1'b0);
        add_vec(6,  6'h00, 1'b0, 6'h01, 1'b0);
        add_vec(8,  6'h04, 1'b0, 6'h01, 1'b0);
        add_vec(10, 6'h00, 1'b0, 6'h05, 1'b0);
        add_vec(11, 6'h00, 1'b0, 6'h05, 1'b1);
        add_vec(13, 6'h04, 1'b0, 6'h05, 1'b0);
        add_vec(15, 6'h00, 1'b0, 6'h05, 1'b1);
        add_vec(16, 6'h00, 1'b0, 6'h04, 1'b0);
        add_vec(18, 6'h04, 1'b0, 6'h04, 1'b0);
        add_vec(20, 6'h00, 1'b0, 6'h04, 1'b0);
        add_vec(24, 6'h00, 1'b0, 6'h04, 1'b0);
        add_vec(28, 6'h00, 1'b0, 6'h04, 1'b0);
        add_vec(30, 6'h02, 1'b0, 6'h04, 1'b0);
        add_vec(31, 6'h00, 1'b0, 6'h04, 1'b1);
        add_vec(32, 6'h00, 1'b0, 6'h02, 1'b0);
        add_vec(34, 6'h10, 1'b0, 6'h02, 1'b0);
        add_vec(36, 6'h00, 1'b1, 6'h00, 1'b0);
        add_vec(37, 6'h00, 1'b0, 6'h00, 1'b0);
        add_vec(40, 6'h10, 1'b0, 6'h00, 1'b0);
        add_vec(42, 6'h00, 1'b0, 6'h10, 1'b0);
        add_vec(43, 6'h00, 1'b0, 6'h10, 1'b1);

        foreach (tv[k]) begin
            run_to(tv[k].p - 1);
            event_in  = tv[k].ev;
            clear_all = tv[k].clr;
            clk();
            event_in  = '0;
            clear_all = 1'b0;
            chk($sformatf("tbl_en@%0d", tv[k].p), 32'(led_enable), 32'(tv[k].en));
            chk($sformatf("tbl_tick@%0d", tv[k].p), 32'(tick), 32'(tv[k].tk));
            chk($sformatf("tbl_mode@%0d", tv[k].p), 32'(mtne_mode), 32'h0);
        end

        // maintenance press-and-hold
        do_reset(1'b0);
        run_to(1);
        mtne_btn = 1'b1;
        run_to(11);
        chk("arm_before_2nd_tick", 32'(mtne_mode), 32'h0);
        clk();
        chk("mtne_on", 32'(mtne_mode), 32'h1);
        run_to(13);
        mtne_btn = 1'b0;
        run_to(17);
        mtne_btn = 1'b1;
        run_to(19);
        chk("on_after_release", 32'(mtne_mode), 32'h1);
        clk();
        chk("mtne_exit", 32'(mtne_mode), 32'h0);
        run_to(21);
        mtne_btn = 1'b0;
        run_to(25);
        mtne_btn = 1'b1;
        run_to(32);
        mtne_btn = 1'b0;
        run_to(40);
        chk("short_press", 32'(mtne_mode), 32'h0);
        run_to(43);
        mtne_btn = 1'b1;
        run_to(51);
        chk("rearm_pending", 32'(mtne_mode), 32'h0);
        clk();
        chk("rearm_on", 32'(mtne_mode), 32'h1);
        run_to(53);
        mtne_btn = 1'b0;

        // reset in the middle of a hold with the FSM in ON
        run_to(55);
        event_in = 6'h01;
        clk();
        event_in = '0;
        run_to(60);
        chk("pre_reset_en", 32'(led_enable), 32'h01);
        chk("pre_reset_mode", 32'(mtne_mode), 32'h1);
        do_reset(1'b1);
        run_to(1);
        mtne_btn = 1'b1;
        run_to(11);
        chk("post_rst_mode", 32'(mtne_mode), 32'h0);
        chk("post_rst_en", 32'(led_enable), 32'h0);
        clk();
        chk("post_rst_arm", 32'(mtne_mode), 32'h1);
        mtne_btn = 1'b0;

        // fault channel 5
        do_reset(1'b0);
        run_to(3);
        event_in = 6'h20;
        clk();
        event_in = '0;
        run_to(15);
        chk("ch5_hold", 32'(led_enable), 32'h20);
        clk();
        chk("ch5_expiry", 32'(led_enable[5]), 32'(STICKY));
        run_to(46);
        chk("ch5_late", 32'(led_enable[5]), 32'(STICKY));
        clear_all = 1'b1;
        clk();
        clear_all = 1'b0;
        chk("ch5_clear", 32'(led_enable), 32'h0);

        // random run against the model
        for (int n = 0; n < 1500; n++) begin
            if (n == 0 || n == 700) begin
                do_reset(1'b0);
                run_to(4);
            end
            for (int b = 0; b < 6; b++) r[b] = ($urandom_range(0, 9) == 0);
            event_in  = r;
            clear_all = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) mtne_btn = ~mtne_btn;
            clk();
            chk($sformatf("rnd_en@%0d", n), 32'(led_enable), 32'(model_en()));
            chk($sformatf("rnd_mode@%0d", n), 32'(mtne_mode), 32'(m_mode));
            chk($sformatf("rnd_tick@%0d", n), 32'(tick), 32'(cur_p % TD == TD - 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_event_timer.md
Name: led_event_timer

Overview:
Upstream stage of the LED pattern driver. Converts six raw event inputs into timed LED enable levels, and runs a press-and-hold state machine that produces the maintenance-mode level. Outputs `led_enable[5:0]` and `mtne_mode` feed the LED pattern driver directly. A shared prescaler provides the timebase, so hold times are expressed in ticks, not clocks.

Parameters:
- TICK_DIV, 10000000, clocks per timebase tick (5 Hz at 50 MHz); must be ≥2.
- HOLD_TICKS, 10, ticks an enable stays high after its last event; must be 1..255.
- MTNE_HOLD_TICKS, 15, ticks `mtne_btn` must be held to enter maintenance; must be 1..255.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- event_in  in  6  per-channel event inputs; a rising edge triggers the channel; asynchronous to logic, so synchronised internally
- clear_all  in  1  synchronous clear of all channels, level-sensitive
- mtne_btn  in  1  maintenance push button, raw, synchronised internally
- led_enable  out  6  registered per-channel enable to the LED driver
- mtne_mode  out  1  registered maintenance level to the LED driver
- tick  out  1  one-clock timebase pulse, for bench and debug

Behaviour:
- Reset (async, active-high):
  - `led_enable` = 0, `mtne_mode` = 0, `tick` = 0.
  - Prescaler, all channel timers, synchronisers and edge-detect history cleared.
  - FSM enters IDLE.
  - Release of reset is synchronous to `clock`; the first post-reset edge is not detected unless the input rises after reset.
- Synchronisers: `event_in` and `mtne_btn` each pass through two flops. Edge detect compares the synchronised value with a third flop. An event edge therefore acts 3 clocks after the input rises.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` is high for exactly one clock when count = TICK_DIV-1.
- Per channel i (8-bit timer):
  - Edge: timer ← HOLD_TICKS and `led_enable[i]` ← 1 on the next clock. A retrigger while active reloads the timer.
  - On `tick`, if timer > 0: timer decrements. When the timer goes 1 → 0, `led_enable[i]` ← 0 in the same clock.
  - Edge and `tick` in the same clock: the reload wins, no decrement.
  - `clear_all` high: all timers ← 0 and `led_enable` ← 0. This beats a simultaneous edge or tick. Edges seen while `clear_all` is high are discarded.
  - An enable lasts from the event to the end of the HOLD_TICKS-th tick after it, i.e. between (HOLD_TICKS-1)·TICK_DIV+1 and HOLD_TICKS·TICK_DIV clocks.
- Maintenance FSM (uses synchronised `btn`; hold counter is 8-bit):
  - IDLE: `btn`=1 → ARM, hold counter ← 0.
  - ARM:
    - `btn`=0 → IDLE.
    - On `tick`: counter increments. When it reaches MTNE_HOLD_TICKS → ON_HELD, and `mtne_mode` ← 1 on that transition.
  - ON_HELD: `btn`=0 → ON.
  - ON: `btn`=1 → EXIT, and `mtne_mode` ← 0 on that transition.
  - EXIT: `btn`=0 → IDLE.
  - `mtne_mode` = 1 only in ON_HELD and ON.
  - `clear_all` does not affect the FSM. Channels keep running during maintenance.
- Reset mid-operation from any state: immediate return to reset values.

Optional Feature:
`LED_EVT_STICKY_EN`
- Defined: channel 5 (fault channel) is sticky. An edge sets `led_enable[5]`, and it stays set, ignoring ticks, until `clear_all` or reset.
- Undefined: channel 5 is timed like channels 0..4.

Test Plan:
Bench parameters: TICK_DIV=4, HOLD_TICKS=3, MTNE_HOLD_TICKS=2.
1. Reset asserted mid-hold with `led_enable`=6'h01 and FSM in ON → same-clock `led_enable`=0 and `mtne_mode`=0; after release, FSM in IDLE.
2. Pulse `event_in[0]` for 1 clock → `led_enable[0]` rises 3 clocks later, then falls on the clock of the 3rd subsequent `tick`; no other bit changes.
3. Retrigger `event_in[2]` 1 clock before the 2nd tick → timer reloads to 3; the enable extends 3 ticks beyond the retrigger. A separate retrigger landing on a `tick` clock → no decrement that clock.
4. `clear_all` high in the same clock as an `event_in[4]` edge → `led_enable`=0 and the edge is discarded; an edge after `clear_all` drops is accepted.
5. Hold `mtne_btn` for 2 ticks → `mtne_mode`=1; release, then press again → `mtne_mode`=0 at the press; release → IDLE. A press released after 1 tick → `mtne_mode` stays 0.
6. With `LED_EVT_STICKY_EN` defined: `event_in[5]` edge → `led_enable[5]` still 1 after 10 ticks; `clear_all` → 0. Without the macro → falls after 3 ticks.
